// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Scan FSM states and BCD code widths/values.
package display_pkg;

  typedef enum logic {
    SHOW  = 1'b0,
    GUARD = 1'b1
  } scan_state_t;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;

endpackage

// File: rtl/scan_prescaler.sv
// Interval counter shared by the SHOW and GUARD phases of the scan.
// Ports: clk, rst_n, clr_i (sync clear), en_i (count), limit_i (last value), tc_o (at limit).
module scan_prescaler #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;

  assign tc_o = (cnt_q == limit_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tc_o ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed refresh controller for an N-digit common-anode 7-seg display.
// Ports: clk, rst_n, enable_i, load_i, digits_i -> bcd_o, an_o (active-low),
// digit_idx_o, frame_tick_o, pending_o. Macro DISPLAY_SCAN_LZB_EN: leading-zero blanking.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 100
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable_i,
  input  logic                          load_i,
  input  logic [BCD_W*N_DIGITS-1:0]     digits_i,
  output logic [BCD_W-1:0]              bcd_o,
  output logic [N_DIGITS-1:0]           an_o,
  output logic [$clog2(N_DIGITS)-1:0]   digit_idx_o,
  output logic                          frame_tick_o,
  output logic                          pending_o
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int DW    = BCD_W * N_DIGITS;
  localparam int MAXL  = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int CNT_W = $clog2(MAXL + 1);

  localparam logic [CNT_W-1:0] SHOW_LIM  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LIM =
    CNT_W'((GUARD_CYCLES == 0) ? 0 : GUARD_CYCLES - 1);
  localparam logic [IDX_W-1:0]    LAST      = IDX_W'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_OFF    = '1;
  localparam logic [N_DIGITS-1:0] AN_ONE    = N_DIGITS'(1);
  localparam logic                HAS_GUARD = (GUARD_CYCLES != 0);

  scan_state_t          state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DW-1:0]        disp_q, disp_d;
  logic [DW-1:0]        pend_q, pend_d;
  logic                 pflag_q, pflag_d;
  logic                 run_q;
  logic [N_DIGITS-1:0]  an_q, an_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic                 tick_q, tick_d;

  logic                 live, tc, step_end;
  logic                 to_guard, adv, wrap, apply, lit;
  logic [CNT_W-1:0]     limit;
  logic [BCD_W-1:0]     nib;
  logic [N_DIGITS-1:0]  blank;
  logic                 hi_zero;

  // run_q marks that the display was lit last cycle; the first enabled
  // cycle after a dark one lights digit 0 with the counter held at zero.
  assign live     = enable_i & run_q;
  assign limit    = (state_q == GUARD) ? GUARD_LIM : SHOW_LIM;
  assign step_end = live & tc;
  assign to_guard = step_end & (state_q == SHOW) & HAS_GUARD;
  assign adv      = step_end & ((state_q == GUARD) | ~HAS_GUARD);
  assign wrap     = adv & (idx_q == LAST);
  assign apply    = pflag_q & (wrap | ~enable_i);

  scan_prescaler #(
    .CNT_W (CNT_W)
  ) u_presc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (~live),
    .en_i    (live),
    .limit_i (limit),
    .tc_o    (tc)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (!enable_i) begin
      state_d = SHOW;
      idx_d   = '0;
    end else if (to_guard) begin
      state_d = GUARD;
    end else if (adv) begin
      state_d = SHOW;
      idx_d   = wrap ? '0 : idx_q + 1'b1;
    end

    disp_d  = apply ? pend_q : disp_q;
    pend_d  = load_i ? digits_i : pend_q;
    pflag_d = load_i | (pflag_q & ~apply);

    nib = BCD_BLANK;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) nib = disp_d[k*BCD_W +: BCD_W];
    end

    // blank[k]: every nibble from k upward is zero (digit 0 never blanks)
    blank   = '0;
    hi_zero = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      hi_zero  = hi_zero & (disp_d[k*BCD_W +: BCD_W] == 4'h0);
      blank[k] = hi_zero;
    end
`ifdef DISPLAY_SCAN_LZB_EN
    for (int k = 1; k < N_DIGITS; k++) begin
      if ((idx_d == IDX_W'(k)) && blank[k]) nib = BCD_BLANK;
    end
`endif

    // Outputs follow the next state so they change on the transition edge.
    lit    = enable_i & (state_d == SHOW);
    an_d   = lit ? ~(AN_ONE << idx_d) : AN_OFF;
    bcd_d  = lit ? nib : BCD_BLANK;
    tick_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SHOW;
      idx_q   <= '0;
      disp_q  <= '1;
      pend_q  <= '1;
      pflag_q <= 1'b0;
      run_q   <= 1'b0;
      an_q    <= AN_OFF;
      bcd_q   <= BCD_BLANK;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
      run_q   <= enable_i;
      an_q    <= an_d;
      bcd_q   <= bcd_d;
      tick_q  <= tick_d;
    end
  end

  assign an_o         = an_q;
  assign bcd_o        = bcd_q;
  assign digit_idx_o  = idx_q;
  assign frame_tick_o = tick_q;
  assign pending_o    = pflag_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Testbench for display_scan_ctrl: time-based model plus directed literal checks.
// N_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=2.
module tb_display_scan_ctrl;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int GC = 2;
  localparam int P  = RD + GC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_i = 1'b0;
  logic        load_i = 1'b0;
  logic [15:0] digits_i = 16'h0;
  logic [3:0]  bcd_o;
  logic [3:0]  an_o;
  logic [1:0]  digit_idx_o;
  logic        frame_tick_o;
  logic        pending_o;

  int total = 0;
  int bad   = 0;

  display_scan_ctrl #(
    .N_DIGITS     (N),
    .REFRESH_DIV  (RD),
    .GUARD_CYCLES (GC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable_i),
    .load_i       (load_i),
    .digits_i     (digits_i),
    .bcd_o        (bcd_o),
    .an_o         (an_o),
    .digit_idx_o  (digit_idx_o),
    .frame_tick_o (frame_tick_o),
    .pending_o    (pending_o)
  );

  always #5 clk = ~clk;

  // Model: t counts cycles since the display lit up; everything else is
  // derived from t by the digit/frame period arithmetic.
  bit          m_live = 0;
  int          m_t = 0;
  logic [15:0] m_disp = 16'hFFFF;
  logic [15:0] m_pend = 16'hFFFF;
  bit          m_flag = 0;
  logic [3:0]  e_an = 4'hF;
  logic [3:0]  e_bcd = 4'hF;
  int          e_idx = 0;
  bit          e_tick = 0;

  task automatic model_reset();
    m_live = 0; m_t = 0;
    m_disp = 16'hFFFF; m_pend = 16'hFFFF; m_flag = 0;
    e_an = 4'hF; e_bcd = 4'hF; e_idx = 0; e_tick = 0;
  endtask

  task automatic model_step();
    bit apply;
    int p, d;
    logic [15:0] hi;
    apply  = 0;
    e_tick = 0;
    if (!enable_i) begin
      m_live = 0;
      apply  = m_flag;
    end else if (!m_live) begin
      m_live = 1;
      m_t    = 0;
    end else begin
      m_t = m_t + 1;
      if ((m_t % P == 0) && ((m_t / P) % N == 0)) begin
        e_tick = 1;
        apply  = m_flag;
      end
    end
    if (apply) begin
      m_disp = m_pend;
      m_flag = 0;
    end
    if (load_i) begin
      m_pend = digits_i;
      m_flag = 1;
    end
    if (!m_live) begin
      e_an = 4'hF; e_bcd = 4'hF; e_idx = 0;
    end else begin
      p = m_t % P;
      d = (m_t / P) % N;
      e_idx = d;
      if (p < RD) begin
        e_an  = ~(4'b0001 << d);
        e_bcd = m_disp[4*d +: 4];
`ifdef DISPLAY_SCAN_LZB_EN
        hi = m_disp >> (4 * d);
        if (d > 0 && hi == 16'h0) e_bcd = 4'hF;
`endif
      end else begin
        e_an  = 4'hF;
        e_bcd = 4'hF;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_step();
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("m_an", 32'(an_o), 32'(e_an));
      chk("m_bcd", 32'(bcd_o), 32'(e_bcd));
      chk("m_idx", 32'(digit_idx_o), 32'(e_idx));
      chk("m_tick", 32'(frame_tick_o), 32'(e_tick));
      chk("m_pend", 32'(pending_o), 32'(m_flag));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_dark(input logic [15:0] v);
    enable_i = 0;
    digits_i = v;
    load_i = 1;
    cyc(1);
    load_i = 0;
    cyc(1);
    enable_i = 1;
    cyc(1);
  endtask

  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] bcd_tab [4] = '{4'h4, 4'h3, 4'h2, 4'h1};

  initial begin
    cyc(2);
    chk("rst_an", 32'(an_o), 32'hF);
    chk("rst_bcd", 32'(bcd_o), 32'hF);
    chk("rst_idx", 32'(digit_idx_o), 0);
    chk("rst_pend", 32'(pending_o), 0);
    rst_n = 1;

    // Basic scan of 1234
    digits_i = 16'h1234;
    load_i = 1;
    cyc(1);
    load_i = 0;
    chk("ld_pend", 32'(pending_o), 1);
    cyc(1);
    chk("ld_applied", 32'(pending_o), 0);
    enable_i = 1;
    for (int i = 0; i <= 24; i++) begin
      cyc(1);
      if (i % P < RD) begin
        chk("scan_an", 32'(an_o), 32'(an_tab[(i / P) % N]));
        chk("scan_bcd", 32'(bcd_o), 32'(bcd_tab[(i / P) % N]));
      end else begin
        chk("guard_an", 32'(an_o), 32'hF);
        chk("guard_bcd", 32'(bcd_o), 32'hF);
      end
      chk("tick", 32'(frame_tick_o), (i == 24) ? 1 : 0);
    end

    // Tear-free load during digit 2 (t=37)
    cyc(12);
    digits_i = 16'h5678;
    load_i = 1;
    cyc(1);
    load_i = 0;
    chk("tf_pend", 32'(pending_o), 1);
    chk("tf_old", 32'(bcd_o), 2);
    cyc(11);
    chk("tf_new", 32'(bcd_o), 8);
    chk("tf_tick", 32'(frame_tick_o), 1);
    chk("tf_clr", 32'(pending_o), 0);

    // Collision: second load on the wrap edge (t=72)
    cyc(1);
    digits_i = 16'h1111;
    load_i = 1;
    cyc(1);
    load_i = 0;
    cyc(21);
    digits_i = 16'h9999;
    load_i = 1;
    cyc(1);
    load_i = 0;
    chk("col_a", 32'(bcd_o), 1);
    chk("col_a_pend", 32'(pending_o), 1);
    cyc(24);
    chk("col_b", 32'(bcd_o), 9);
    chk("col_b_pend", 32'(pending_o), 0);

    // Enable drop during guard of digit 1 (t=106)
    cyc(10);
    chk("drop_guard", 32'(an_o), 32'hF);
    chk("drop_gidx", 32'(digit_idx_o), 1);
    enable_i = 0;
    cyc(1);
    chk("drop_an", 32'(an_o), 32'hF);
    chk("drop_idx", 32'(digit_idx_o), 0);
    cyc(2);
    enable_i = 1;
    cyc(1);
    chk("reen_an", 32'(an_o), 32'hE);
    chk("reen_bcd", 32'(bcd_o), 9);

    // Out-of-range codes pass through
    load_dark(16'hEDCA);
    chk("pass_a", 32'(bcd_o), 32'hA);
    cyc(6);
    chk("pass_c", 32'(bcd_o), 32'hC);

`ifdef DISPLAY_SCAN_LZB_EN
    load_dark(16'h0040);
    chk("lzb_d0", 32'(bcd_o), 0);
    cyc(6);
    chk("lzb_d1", 32'(bcd_o), 4);
    cyc(6);
    chk("lzb_d2", 32'(bcd_o), 32'hF);
    chk("lzb_an2", 32'(an_o), 32'hB);
    cyc(6);
    chk("lzb_d3", 32'(bcd_o), 32'hF);
    load_dark(16'h0000);
    chk("lzb0_d0", 32'(bcd_o), 0);
    cyc(6);
    chk("lzb0_d1", 32'(bcd_o), 32'hF);
`endif

    // Asynchronous reset mid-scan with a load pending
    digits_i = 16'h1357;
    load_i = 1;
    cyc(1);
    load_i = 0;
    cyc(8);
    #2 rst_n = 0;
    #1;
    chk("arst_an", 32'(an_o), 32'hF);
    chk("arst_bcd", 32'(bcd_o), 32'hF);
    chk("arst_idx", 32'(digit_idx_o), 0);
    chk("arst_pend", 32'(pending_o), 0);
    chk("arst_tick", 32'(frame_tick_o), 0);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
